recepcion: RTL
==============

// Module: recepcion
// PURPOSE
//  UART receiver (8N1, LSB first): the serial-in counterpart of the transmision block.
//  Synchronises the async rx line, detects the start bit and samples each bit mid-period.
//  Delivers the received byte on dout with a one-cycle done strobe.
//  Sits between the Bluetooth module's TX pin and the game command decoder.
// PARAMETERS
//  CLKS_PER_BIT  5208  clk_in cycles per bit (50 MHz / 9600 baud); must be even and >= 8
// PORTS
//  clk_in     in   1  system clock, all logic on rising edge
//  reset      in   1  asynchronous, active-high; clears all state
//  rx         in   1  serial line, idle high, asynchronous to clk_in
//  dout       out  8  last correctly framed byte; holds until the next good frame
//  done       out  1  one-cycle pulse: dout has just been updated
//  busy       out  1  high while a frame is being received
//  frame_err  out  1  one-cycle pulse: stop bit sampled low
//  parity_err out  1  one-cycle pulse: parity mismatch (tied 0 unless RX_PARITY_EN)
// BEHAVIOUR
//  - Reset: dout=0, done=0, busy=0, frame_err=0, parity_err=0, state=IDLE, counters=0.
//    Both synchroniser flops reset to 1 (idle line). Reset mid-frame aborts with no strobe.
//  - rx passes a 2-flop synchroniser; all decisions use rx_s (2-cycle latency).
//  - Bit counter: 0..CLKS_PER_BIT-1, wraps to 0. Index counter 0..7.
//  - IDLE: busy=0. rx_s==0 -> START, clear counter.
//  - START: busy=1. At count CLKS_PER_BIT/2-1 (mid start bit):
//    rx_s==0 -> DATA, counter=0; rx_s==1 -> glitch, back to IDLE, no flag.
//  - DATA: at each counter wrap (CLKS_PER_BIT-1), shift rx_s into shreg MSB
//    (shift right, so LSB-first). After the 8th sample -> STOP (or PARITY).
//  - STOP: at counter wrap, sample rx_s:
//    1 -> dout<=shreg, done=1 for one cycle, next state IDLE (same edge);
//    0 -> frame_err=1 for one cycle, dout unchanged, no done, next state BREAK.
//  - BREAK: busy=1; waits for rx_s==1, then IDLE (prevents retrigger on a held-low line).
//  - Back-to-back frames: IDLE is re-entered at mid stop bit, so the next start edge
//    is always caught; no minimum inter-frame gap beyond the single stop bit.
//  - done, frame_err, parity_err are never high simultaneously except done+parity_err.
//  - busy is combinational on state != IDLE (registered state), glitch-free.
// CONFIGURATION
//  RX_PARITY_EN defined: frame is 8E1. State PARITY between DATA and STOP samples one
//    bit at counter wrap; stored mismatch (XOR of 8 data bits != parity bit) drives
//    parity_err=1 in the same cycle as done; dout is still updated.
//  RX_PARITY_EN undefined: 8N1, no PARITY state, parity_err constant 0.
// TESTING  (CLKS_PER_BIT=16, bit period 16 clocks; reset asserted first)
//  1 reset, then frame 8'h33 on rx -> done high exactly one cycle, 152-156 cycles after
//    rx falling edge; dout=8'h33; busy 1 from edge+3 until done; frame_err stays 0.
//  2 rx low for 4 cycles then high -> busy pulses, returns 0 by cycle 12; no done, dout unchanged.
//  3 frame 8'hA5 with stop bit 0, rx held low 40 more cycles -> frame_err one-cycle pulse,
//    no done, dout keeps previous value, busy stays 1 until rx high, then 0.
//  4 frames 8'hA5 then 8'h5A, one stop bit each, no gap -> two done pulses, 160 cycles
//    apart, dout=8'hA5 then 8'h5A.
//  5 reset pulsed during data bit 3 of 8'hFF -> next edge: busy=0, dout=0, no done;
//    following frame 8'h0F received correctly.
//  6 RX_PARITY_EN: 8'h07 with parity 1 -> done, parity_err=0; with parity 0 -> done and
//    parity_err together, dout=8'h07; non-macro build: parity_err always 0.

Source files
------------

// File: rtl/recepcion.sv
// rtl/recepcion.sv - UART receiver, 8N1 LSB first; RX_PARITY_EN selects 8E1 with parity_err reporting
module recepcion #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] dout,
    output logic       done,
    output logic       busy,
    output logic       frame_err,
    output logic       parity_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    logic          rx_meta_q, rx_s_q;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    dout_q, dout_d;
    logic          done_q, done_d;
    logic          ferr_q, ferr_d;
`ifdef RX_PARITY_EN
    logic          pmis_q, pmis_d;
    logic          perr_q, perr_d;
`endif

    // Two-flop synchroniser; both stages idle high so reset never fakes a start bit
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Receiver state and datapath registers
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef RX_PARITY_EN
            pmis_q  <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
`ifdef RX_PARITY_EN
            pmis_q  <= pmis_d;
            perr_q  <= perr_d;
`endif
        end
    end

    // Next state: start bit checked at its middle, later bits sampled one period apart
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        idx_d   = idx_q;
        shreg_d = shreg_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
`ifdef RX_PARITY_EN
        pmis_d  = pmis_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    shreg_d = {rx_s_q, shreg_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    pmis_d  = (^shreg_q) != rx_s_q;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    if (rx_s_q) begin
                        dout_d  = shreg_q;
                        done_d  = 1'b1;
`ifdef RX_PARITY_EN
                        perr_d  = pmis_q;
`endif
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign dout      = dout_q;
    assign done      = done_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != S_IDLE);
`ifdef RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif
endmodule
